spi_flash_arbiter: RTL
======================

# spi_flash_arbiter

Fixed-priority, non-preemptive arbiter sharing the single configuration SPI flash bus between two masters: requester A (the JTAG-to-SPI bridge) and requester B (user logic, e.g. a soft-core boot loader). It sits between both masters and the flash pins. It grants the bus to one master at a time and registers the granted master's CSB/MOSI/SCK onto the pins. It enforces a CSB-high guard interval between owners. It routes MISO back only to the owner.

## Interface
- GUARD_CYCLES, 4: CLK cycles CSB is forced high after a grant ends; legal range 1..255.
- TIMEOUT_CYCLES, 50000: maximum B ownership in CLK cycles when timeout is compiled in; legal range 2..65535.
- CLK  input  1  sole clock; every register updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- A_REQ, B_REQ  input  1  bus request, level; held for the whole transaction.
- A_GNT, B_GNT  output  1  grant, registered; never both 1.
- A_CSB, A_MOSI, A_SCK  input  1 each  requester A SPI drive, synchronous to CLK.
- B_CSB, B_MOSI, B_SCK  input  1 each  requester B SPI drive, synchronous to CLK.
- A_MISO, B_MISO  output  1 each  flash MISO to owner; 0 to non-owner.
- B_TIMEOUT  output  1  sticky flag: B's grant was revoked by the watchdog.
- CSB, MOSI, SCK  output  1 each  flash pins, registered.
- MISO  input  1  flash data out.

## Operation
- States: IDLE, OWN_A, OWN_B, GUARD.
- IDLE:
  - A_REQ=1 -> OWN_A; else B_REQ=1 and B_TIMEOUT=0 -> OWN_B.
  - Simultaneous requests: A wins.
- OWN_A:
  - A_GNT=1; pins follow A_CSB/A_MOSI/A_SCK.
  - A_REQ=0 -> GUARD. B_REQ is ignored; no preemption.
- OWN_B:
  - B_GNT=1; pins follow B_*.
  - B_REQ=0 -> GUARD. A waits; no preemption.
- GUARD:
  - No grant; CSB=1, SCK=0, MOSI=0.
  - Guard counter loads GUARD_CYCLES-1 on entry and counts down. At 0 -> IDLE.
  - Requests arriving in GUARD are held pending and evaluated in IDLE.
- In IDLE and GUARD the pins are CSB=1, SCK=0, MOSI=0.
- MISO routing is combinational from MISO and the current grant register. The non-owner's MISO reads 0.
- B_TIMEOUT clears on the first cycle B_REQ=0 is sampled. While B_TIMEOUT=1, B is not granted.

## Timing
- Reset values:
  - A_GNT=0, B_GNT=0, B_TIMEOUT=0.
  - CSB=1, MOSI=0, SCK=0.
  - state=IDLE, counters=0.
- Grant latency: REQ sampled 1 in IDLE at edge n -> GNT=1 after edge n.
- Pin latency: requester drive sampled at edge k appears on the pins after edge k while GNT=1. The pins lag the requester's signals by exactly one cycle.
- The first pin cycle of a grant carries the owner's value sampled on the grant edge. Requesters hold CSB=1 until they observe GNT=1.
- Release: REQ=0 sampled at edge m -> GNT=0 and CSB=1 after edge m.
  - GUARD lasts exactly GUARD_CYCLES cycles.
  - The earliest next grant is after edge m+GUARD_CYCLES+1.
- Back-to-back by the same master: that master drops REQ for at least one cycle and pays the guard.
- Reset mid-transfer: CSB=1 and GNT=0 after the reset edge, regardless of state.
- GNT deasserts on the same edge as CSB forced high, so no partial clocking follows a revoke.

## Configuration
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to OWN_B and increments each OWN_B cycle.
  - When it reaches TIMEOUT_CYCLES-1 while still in OWN_B, the next edge does three things: B_GNT=0, B_TIMEOUT=1, state -> GUARD.
  - B ownership is therefore at most TIMEOUT_CYCLES cycles.
- Undefined:
  - There is no counter, and B_TIMEOUT is constant 0.
  - B owns the bus until it drops B_REQ.

## Test plan
- Reset, then idle for 10 cycles -> CSB=1, SCK=0, MOSI=0, both GNT=0, B_TIMEOUT=0.
- A_REQ=1 at cycle 5, A drives CSB=0 plus 8 SCK toggles, MISO=1 -> A_GNT=1 after cycle 5. The pins mirror A one cycle late. A_MISO=1 and B_MISO=0.
- A_REQ and B_REQ rise on the same cycle in IDLE -> A_GNT=1 and B_GNT=0.
  - A drops its request at cycle 20 -> 4 guard cycles with CSB=1 and no grant.
  - B_GNT=1 after edge 25.
- B owns the bus and A_REQ rises mid-transfer -> B keeps the bus; A_GNT stays 0 until B releases and the guard completes.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, B holds B_REQ for 500 cycles:
  - B_GNT drops after exactly 100 granted cycles, CSB=1, B_TIMEOUT=1.
  - No re-grant until B_REQ=0; B_TIMEOUT then clears.
  - Without the macro, B keeps the grant for all 500 cycles.
- RESET pulsed while OWN_A has CSB=0 -> CSB=1 and A_GNT=0 after the reset edge, state IDLE. A grant is possible on the next cycle.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: fixed-priority, non-preemptive owner select for one SPI flash bus
// shared by requester A (JTAG bridge, high priority) and requester B (user logic).
//
// Optional build macro: SPI_ARB_TIMEOUT_EN adds a watchdog on B ownership
// (TIMEOUT_CYCLES parameter) and a sticky b_timeout_o flag. Without it b_timeout_o is 0.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   a_req_i, b_req_i                level bus requests
//   a_gnt_o, b_gnt_o                registered grants, mutually exclusive
//   a_csb_i, a_mosi_i, a_sck_i      requester A SPI drive
//   b_csb_i, b_mosi_i, b_sck_i      requester B SPI drive
//   a_miso_o, b_miso_o              flash MISO routed to the current owner only
//   b_timeout_o                     B grant was revoked by the watchdog
//   csb_o, mosi_o, sck_o            registered flash pins
//   miso_i                          flash data out
module spi_flash_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 4
`ifdef SPI_ARB_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic a_gnt_o,
    output logic b_gnt_o,
    input  logic a_csb_i,
    input  logic a_mosi_i,
    input  logic a_sck_i,
    input  logic b_csb_i,
    input  logic b_mosi_i,
    input  logic b_sck_i,
    output logic a_miso_o,
    output logic b_miso_o,
    output logic b_timeout_o,
    output logic csb_o,
    output logic mosi_o,
    output logic sck_o,
    input  logic miso_i
);

    localparam int unsigned GuardW    = 8;
    localparam logic [GuardW-1:0] GuardLoad = GuardW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        GUARD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [GuardW-1:0] guard_q, guard_d;
    logic              a_gnt_q, a_gnt_d;
    logic              b_gnt_q, b_gnt_d;
    logic              csb_q, csb_d;
    logic              mosi_q, mosi_d;
    logic              sck_q, sck_d;
    logic              b_block_c;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TimeoutW = 16;
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

    logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
    logic                b_to_q, b_to_d;

    assign b_block_c   = b_to_q;
    assign b_timeout_o = b_to_q;
`else
    assign b_block_c   = 1'b0;
    assign b_timeout_o = 1'b0;
`endif

    // Next-state, guard countdown and pin selection for the next owner
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        // Flag persists until B is seen to let go of its request
        b_to_d   = b_req_i ? b_to_q : 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (a_req_i) begin
                    state_d = OWN_A;
                end else if (b_req_i && !b_block_c) begin
                    state_d = OWN_B;
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            OWN_A: begin
                if (!a_req_i) begin
                    state_d = GUARD;
                    guard_d = GuardLoad;
                end
            end
            OWN_B: begin
                if (!b_req_i) begin
                    state_d = GUARD;
                    guard_d = GuardLoad;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (to_cnt_q == TimeoutLast) begin
                    state_d = GUARD;
                    guard_d = GuardLoad;
                    b_to_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TimeoutW'(1);
                end
`endif
            end
            GUARD: begin
                if (guard_q == '0) begin
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q - GuardW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins and grants follow the state being entered, so revoke and CSB high coincide
        a_gnt_d = (state_d == OWN_A);
        b_gnt_d = (state_d == OWN_B);
        csb_d   = 1'b1;
        mosi_d  = 1'b0;
        sck_d   = 1'b0;
        if (state_d == OWN_A) begin
            csb_d  = a_csb_i;
            mosi_d = a_mosi_i;
            sck_d  = a_sck_i;
        end else if (state_d == OWN_B) begin
            csb_d  = b_csb_i;
            mosi_d = b_mosi_i;
            sck_d  = b_sck_i;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            guard_q <= '0;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            csb_q   <= 1'b1;
            mosi_q  <= 1'b0;
            sck_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            a_gnt_q <= a_gnt_d;
            b_gnt_q <= b_gnt_d;
            csb_q   <= csb_d;
            mosi_q  <= mosi_d;
            sck_q   <= sck_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            to_cnt_q <= '0;
            b_to_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            b_to_q   <= b_to_d;
        end
    end
`endif

    assign a_gnt_o  = a_gnt_q;
    assign b_gnt_o  = b_gnt_q;
    assign csb_o    = csb_q;
    assign mosi_o   = mosi_q;
    assign sck_o    = sck_q;
    // MISO steered combinationally by the registered grant
    assign a_miso_o = a_gnt_q & miso_i;
    assign b_miso_o = b_gnt_q & miso_i;

endmodule
